// File: rtl/mem_arb_pkg.sv
// Shared types and default sizing for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

    localparam int AW_DEF         = 8;
    localparam int DW_DEF         = 32;
    localparam int STARVE_MAX_DEF = 4;
    localparam int CNT_W_DEF      = 16;

    // Owner of the read data returning from memory in the current cycle
    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF_RD = 2'd1,
        OWN_D_RD  = 2'd2,
        OWN_D_WR  = 2'd3
    } own_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and memory-side signals for mem_port_arbiter.
// slave = arbiter side, master = pipeline/memory environment side.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic             i_if_req;
    logic [AW-1:0]    i_if_addr;
    logic             o_if_gnt;
    logic             o_if_rvalid;
    logic [DW-1:0]    o_if_rdata;
    logic             i_d_req;
    logic             i_d_we;
    logic [AW-1:0]    i_d_addr;
    logic [DW-1:0]    i_d_wdata;
    logic             o_d_gnt;
    logic             o_d_rvalid;
    logic [DW-1:0]    o_d_rdata;
    logic [AW-1:0]    o_mem_addr;
    logic [DW-1:0]    o_mem_wdata;
    logic             o_mem_read;
    logic             o_mem_write;
    logic [DW-1:0]    i_mem_rdata;
    logic [CNT_W-1:0] o_conflict_cnt;
    logic [CNT_W-1:0] o_if_stall_cnt;

    modport slave (
        input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
        output o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
               o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write,
               o_conflict_cnt, o_if_stall_cnt
    );

    modport master (
        output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_mem_rdata,
        input  o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
               o_mem_addr, o_mem_wdata, o_mem_read, o_mem_write,
               o_conflict_cnt, o_if_stall_cnt
    );

endinterface

// File: rtl/mem_arb_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX once reached.
module mem_arb_sat_counter #(
    parameter int           W   = 4,
    parameter logic [W-1:0] MAX = {W{1'b1}}
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    localparam logic [W-1:0] ONE_C = W'(1'b1);

    logic [W-1:0] cnt_r;

    // Count state: reset/clear to zero, increment until MAX
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r <= {W{1'b0}};
        end else if (i_clr) begin
            cnt_r <= {W{1'b0}};
        end else if (i_inc && (cnt_r != MAX)) begin
            cnt_r <= cnt_r + ONE_C;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_cnt = cnt_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 1-cycle-latency memory between fetch and data requesters.
// Optional performance counters are enabled with `define MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int STARVE_MAX = STARVE_MAX_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_reset,
    mem_port_arbiter_if.slave  bus
);
    localparam int          STARVE_W     = 4;
    localparam logic [3:0]  STARVE_MAX_C = 4'(STARVE_MAX);

    logic                if_gnt_s;
    logic                d_gnt_s;
    logic [STARVE_W-1:0] starve_cnt_s;
    logic                starve_clr_s;
    logic                starve_inc_s;
    logic [AW-1:0]       mem_addr_s;
    logic [DW-1:0]       mem_wdata_s;
    logic                mem_read_s;
    logic                mem_write_s;
    logic                if_rvalid_s;
    logic [DW-1:0]       if_rdata_s;
    logic                d_rvalid_s;
    logic [DW-1:0]       d_rdata_s;
    own_e                own_r;

    // Per-cycle arbitration: data wins a conflict unless fetch has starved STARVE_MAX cycles
    always_comb begin
        if_gnt_s = 1'b0;
        d_gnt_s  = 1'b0;
        if (i_reset) begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end else if (bus.i_if_req && bus.i_d_req) begin
            if (starve_cnt_s == STARVE_MAX_C) begin
                if_gnt_s = 1'b1;
            end else begin
                d_gnt_s = 1'b1;
            end
        end else if (bus.i_if_req) begin
            if_gnt_s = 1'b1;
        end else if (bus.i_d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            if_gnt_s = 1'b0;
            d_gnt_s  = 1'b0;
        end
    end

    // Memory command follows the granted requester in the same cycle
    always_comb begin
        mem_addr_s  = {AW{1'b0}};
        mem_wdata_s = {DW{1'b0}};
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
        if (if_gnt_s) begin
            mem_addr_s = bus.i_if_addr;
            mem_read_s = 1'b1;
        end else if (d_gnt_s) begin
            mem_addr_s  = bus.i_d_addr;
            mem_wdata_s = bus.i_d_wdata;
            mem_read_s  = ~bus.i_d_we;
            mem_write_s = bus.i_d_we;
        end else begin
            mem_addr_s  = {AW{1'b0}};
            mem_wdata_s = {DW{1'b0}};
        end
    end

    assign starve_clr_s = ~bus.i_if_req | if_gnt_s;
    assign starve_inc_s = bus.i_if_req & ~if_gnt_s;

    mem_arb_sat_counter #(
        .W   (STARVE_W),
        .MAX (STARVE_MAX_C)
    ) u_starve_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (starve_clr_s),
        .i_inc   (starve_inc_s),
        .o_cnt   (starve_cnt_s)
    );

    // Response-owner FSM: remembers who owns the read data arriving next cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            own_r <= OWN_NONE;
        end else if (if_gnt_s) begin
            own_r <= OWN_IF_RD;
        end else if (d_gnt_s) begin
            own_r <= bus.i_d_we ? OWN_D_WR : OWN_D_RD;
        end else begin
            own_r <= OWN_NONE;
        end
    end

    // Route memory read data to its owner; a pending read is dropped while reset is high
    always_comb begin
        if_rvalid_s = 1'b0;
        if_rdata_s  = {DW{1'b0}};
        d_rvalid_s  = 1'b0;
        d_rdata_s   = {DW{1'b0}};
        if (!i_reset) begin
            case (own_r)
                OWN_IF_RD: begin
                    if_rvalid_s = 1'b1;
                    if_rdata_s  = bus.i_mem_rdata;
                end
                OWN_D_RD: begin
                    d_rvalid_s = 1'b1;
                    d_rdata_s  = bus.i_mem_rdata;
                end
                default: begin
                    if_rvalid_s = 1'b0;
                    d_rvalid_s  = 1'b0;
                end
            endcase
        end else begin
            if_rvalid_s = 1'b0;
            d_rvalid_s  = 1'b0;
        end
    end

    assign bus.o_if_gnt    = if_gnt_s;
    assign bus.o_d_gnt     = d_gnt_s;
    assign bus.o_mem_addr  = mem_addr_s;
    assign bus.o_mem_wdata = mem_wdata_s;
    assign bus.o_mem_read  = mem_read_s;
    assign bus.o_mem_write = mem_write_s;
    assign bus.o_if_rvalid = if_rvalid_s;
    assign bus.o_if_rdata  = if_rdata_s;
    assign bus.o_d_rvalid  = d_rvalid_s;
    assign bus.o_d_rdata   = d_rdata_s;

`ifdef MEM_ARB_PERF_CNT_EN
    mem_arb_sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_conflict_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (bus.i_if_req & bus.i_d_req),
        .o_cnt   (bus.o_conflict_cnt)
    );

    mem_arb_sat_counter #(
        .W   (CNT_W),
        .MAX ({CNT_W{1'b1}})
    ) u_if_stall_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clr   (1'b0),
        .i_inc   (bus.i_if_req & ~if_gnt_s),
        .o_cnt   (bus.o_if_stall_cnt)
    );
`else
    assign bus.o_conflict_cnt = {CNT_W{1'b0}};
    assign bus.o_if_stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a read-data scoreboard.
module tb_mem_port_arbiter;

    localparam int AW         = 8;
    localparam int DW         = 32;
    localparam int STARVE_MAX = 4;
    localparam int CNT_W      = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW), .CNT_W(CNT_W)) bus ();

    mem_port_arbiter #(
        .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .CNT_W(CNT_W)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // Memory instance model and an independent reference copy for the scoreboard
    logic [DW-1:0] mem     [0:255];
    logic [DW-1:0] ref_mem [0:255];
    logic [DW-1:0] mem_rdata_r;

    always @(posedge clk) begin
        if (bus.o_mem_write) mem[bus.o_mem_addr] <= bus.o_mem_wdata;
        if (bus.o_mem_read)  mem_rdata_r <= mem[bus.o_mem_addr];
    end
    assign bus.i_mem_rdata = mem_rdata_r;

    int n_vec = 0;
    int n_err = 0;
    int exp_conf = 0;
    int exp_stall = 0;
    logic [DW-1:0] q_if [$];
    logic [DW-1:0] q_d  [$];
    logic pend_if = 1'b0;
    logic pend_d  = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle: inputs already driven; check responses, grants and memory command
    task automatic cyc(input logic e_if, input logic e_d);
        logic [DW-1:0] e;
        #1;
        check("if_rvalid", {63'd0, bus.o_if_rvalid}, {63'd0, pend_if & ~rst});
        check("d_rvalid",  {63'd0, bus.o_d_rvalid},  {63'd0, pend_d & ~rst});
        if (pend_if) begin
            e = q_if.pop_front();
            if (!rst) check("if_rdata", {32'd0, bus.o_if_rdata}, {32'd0, e});
        end else begin
            check("if_rdata_idle", {32'd0, bus.o_if_rdata}, 64'd0);
        end
        if (pend_d) begin
            e = q_d.pop_front();
            if (!rst) check("d_rdata", {32'd0, bus.o_d_rdata}, {32'd0, e});
        end else begin
            check("d_rdata_idle", {32'd0, bus.o_d_rdata}, 64'd0);
        end
        check("if_gnt", {63'd0, bus.o_if_gnt}, {63'd0, e_if});
        check("d_gnt",  {63'd0, bus.o_d_gnt},  {63'd0, e_d});
        if (e_if) begin
            check("mem_cmd_if", {bus.o_mem_read, bus.o_mem_write, bus.o_mem_addr},
                  {1'b1, 1'b0, bus.i_if_addr});
            q_if.push_back(ref_mem[bus.i_if_addr]);
        end else if (e_d) begin
            check("mem_cmd_d", {bus.o_mem_read, bus.o_mem_write, bus.o_mem_addr, bus.o_mem_wdata},
                  {~bus.i_d_we, bus.i_d_we, bus.i_d_addr, bus.i_d_we ? bus.i_d_wdata : 32'd0});
            if (bus.i_d_we) ref_mem[bus.i_d_addr] = bus.i_d_wdata;
            else            q_d.push_back(ref_mem[bus.i_d_addr]);
        end else begin
            check("mem_cmd_idle", {bus.o_mem_read, bus.o_mem_write, bus.o_mem_addr, bus.o_mem_wdata}, 64'd0);
        end
        pend_if = e_if;
        pend_d  = e_d & ~bus.i_d_we;
        if (rst) begin
            exp_conf  = 0;
            exp_stall = 0;
        end else begin
            if (bus.i_if_req && bus.i_d_req) exp_conf++;
            if (bus.i_if_req && !e_if)       exp_stall++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_cnts(input string tag);
        logic [CNT_W-1:0] ec;
        logic [CNT_W-1:0] es;
`ifdef MEM_ARB_PERF_CNT_EN
        ec = CNT_W'(exp_conf);
        es = CNT_W'(exp_stall);
`else
        ec = {CNT_W{1'b0}};
        es = {CNT_W{1'b0}};
`endif
        check({tag, "_conflict"}, {48'd0, bus.o_conflict_cnt}, {48'd0, ec});
        check({tag, "_stall"},    {48'd0, bus.o_if_stall_cnt}, {48'd0, es});
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hA5000000 | 32'(i * 7);
            ref_mem[i] = 32'hA5000000 | 32'(i * 7);
        end
        mem[8'h10]     = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        bus.i_if_req  = 1'b0;
        bus.i_if_addr = 8'h00;
        bus.i_d_req   = 1'b0;
        bus.i_d_we    = 1'b0;
        bus.i_d_addr  = 8'h00;
        bus.i_d_wdata = 32'h0;

        // Reset state, including requests active during reset
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        bus.i_if_req = 1'b1; bus.i_d_req = 1'b1;
        cyc(1'b0, 1'b0);
        check_cnts("reset");
        bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
        rst = 1'b0;
        cyc(1'b0, 1'b0);

        // Fetch-only read
        bus.i_if_req = 1'b1; bus.i_if_addr = 8'h10;
        cyc(1'b1, 1'b0);
        bus.i_if_req = 1'b0;
        cyc(1'b0, 1'b0);

        // Data write then read back
        bus.i_d_req = 1'b1; bus.i_d_we = 1'b1; bus.i_d_addr = 8'h20; bus.i_d_wdata = 32'h12345678;
        cyc(1'b0, 1'b1);
        bus.i_d_we = 1'b0; bus.i_d_wdata = 32'h0;
        cyc(1'b0, 1'b1);
        bus.i_d_req = 1'b0;
        cyc(1'b0, 1'b0);

        // Reset mid-read: granted read must not return
        bus.i_d_req = 1'b1; bus.i_d_addr = 8'h30;
        cyc(1'b0, 1'b1);
        bus.i_d_req = 1'b0;
        rst = 1'b1;
        cyc(1'b0, 1'b0);
        rst = 1'b0;
        cyc(1'b0, 1'b0);
        check_cnts("post_reset");

        // Continuous conflict: four data grants, then fetch on the fifth
        bus.i_if_req = 1'b1; bus.i_if_addr = 8'h10;
        bus.i_d_req  = 1'b1; bus.i_d_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus.i_d_addr = 8'(8'h40 + k);
            cyc((k == 4) || (k == 9), !((k == 4) || (k == 9)));
        end
        bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
        cyc(1'b0, 1'b0);
        check_cnts("conflict");
`ifdef MEM_ARB_PERF_CNT_EN
        check("conflict_cnt_10", {48'd0, bus.o_conflict_cnt}, 64'd10);
        check("stall_cnt_8",     {48'd0, bus.o_if_stall_cnt}, 64'd8);
`endif

        // Alternating fetch/data reads every cycle
        for (int k = 0; k < 8; k++) begin
            if ((k % 2) == 0) begin
                bus.i_if_req = 1'b1; bus.i_if_addr = 8'(8'h50 + k); bus.i_d_req = 1'b0;
                cyc(1'b1, 1'b0);
            end else begin
                bus.i_if_req = 1'b0; bus.i_d_req = 1'b1; bus.i_d_we = 1'b0; bus.i_d_addr = 8'(8'h60 + k);
                cyc(1'b0, 1'b1);
            end
        end
        bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
        cyc(1'b0, 1'b0);

        // Fetch denied twice, then drops: starvation count must restart from zero
        bus.i_if_req = 1'b1; bus.i_d_req = 1'b1; bus.i_d_addr = 8'h70;
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b1);
        bus.i_if_req = 1'b0;
        cyc(1'b0, 1'b1);
        bus.i_if_req = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1'b0, 1'b1);
        cyc(1'b1, 1'b0);
        bus.i_if_req = 1'b0; bus.i_d_req = 1'b0;
        cyc(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
